// File: rtl/redraw_pkg.sv
// Shared constants for the background redraw path: game-state codes, screen geometry and region table.
// No logic or latency; region bounds are guaranteed to lie inside the screen.
package redraw_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COLOUR_W = 9;
    localparam int ADDR_W   = 17;
    localparam logic [COLOUR_W-1:0] KEY_COLOUR = 9'h000;

    localparam logic [3:0] GS_INITIAL         = 4'd0;
    localparam logic [3:0] GS_UPDATE_BRIDGE_1 = 4'd1;
    localparam logic [3:0] GS_FORMED_BRIDGE_1 = 4'd2;
    localparam logic [3:0] GS_UPDATE_BRIDGE_2 = 4'd3;
    localparam logic [3:0] GS_FORMED_BRIDGE_2 = 4'd4;
    localparam logic [3:0] GS_UPDATE_BRIDGE_3 = 4'd5;
    localparam logic [3:0] GS_FORMED_BRIDGE_3 = 4'd6;
    localparam logic [3:0] GS_UPDATE_PILLAR   = 4'd7;
    localparam logic [3:0] GS_PILLAR_RISED    = 4'd8;
    localparam logic [3:0] GS_FINISHED_GAME   = 4'd9;
    localparam logic [3:0] GS_DRAW_INITIAL    = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SWEEP,
        ST_FLUSH,
        ST_DONE
    } redraw_state_e;

    typedef struct packed {
        logic [8:0] x0;
        logic [7:0] y0;
        logic [8:0] w;
        logic [7:0] h;
        logic [2:0] sel;
    } region_t;

    function automatic logic is_redraw_state(input logic [3:0] gs);
        return (gs == GS_DRAW_INITIAL)    || (gs == GS_UPDATE_BRIDGE_1) ||
               (gs == GS_UPDATE_BRIDGE_2) || (gs == GS_UPDATE_BRIDGE_3) ||
               (gs == GS_UPDATE_PILLAR);
    endfunction

    // Bridge and pillar boxes are placeholders until the art is final.
    function automatic region_t region_lookup(input logic [3:0] gs);
        region_t r;
        r = '0;
        case (gs)
            GS_DRAW_INITIAL: begin
                r.x0 = 9'd0;  r.y0 = 8'd0;  r.w = 9'd320; r.h = 8'd240; r.sel = 3'd0;
            end
            GS_UPDATE_BRIDGE_1: begin
                r.x0 = 9'd0;  r.y0 = 8'd0;  r.w = 9'd8;   r.h = 8'd4;   r.sel = 3'd1;
            end
            GS_UPDATE_BRIDGE_2: begin
                r.x0 = 9'd8;  r.y0 = 8'd4;  r.w = 9'd8;   r.h = 8'd4;   r.sel = 3'd2;
            end
            GS_UPDATE_BRIDGE_3: begin
                r.x0 = 9'd16; r.y0 = 8'd8;  r.w = 9'd8;   r.h = 8'd4;   r.sel = 3'd3;
            end
            GS_UPDATE_PILLAR: begin
                r.x0 = 9'd24; r.y0 = 8'd12; r.w = 9'd8;   r.h = 8'd4;   r.sel = 3'd4;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/redraw_addr_gen.sv
// Raster x/y counters over a rectangular region, frame ROM address (y*320+x) and last-pixel flag.
// Address is combinational from the counters; advances one pixel per step, no backpressure.
module redraw_addr_gen
    import redraw_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic              step,
    input  logic [8:0]        x0,
    input  logic [7:0]        y0,
    input  logic [8:0]        w,
    input  logic [7:0]        h,
    output logic [8:0]        x,
    output logic [7:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [8:0] rowStart;
    logic [8:0] xEnd;
    logic [7:0] yEnd;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x        <= '0;
            y        <= '0;
            rowStart <= '0;
            xEnd     <= '0;
            yEnd     <= '0;
        end else if (load) begin
            x        <= x0;
            y        <= y0;
            rowStart <= x0;
            xEnd     <= x0 + w - 9'd1;
            yEnd     <= y0 + h - 8'd1;
        end else if (step) begin
            if (x == xEnd) begin
                x <= rowStart;
                y <= y + 8'd1;
            end else begin
                x <= x + 9'd1;
            end
        end
    end

    // 320 = 256 + 64, so the row offset is two shifted copies of y.
    assign addr = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
    assign last = (x == xEnd) && (y == yEnd);

endmodule

// File: rtl/background_redraw_ctrl.sv
// Redraws the background region of each redraw game state from frame ROM, one VGA write per pixel.
// Trigger to doneRedraw is w*h+3 cycles, no backpressure; REDRAW_TRANSPARENT_EN skips KEY_COLOUR pixels.
module background_redraw_ctrl
    import redraw_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic [3:0]          gameState,
    output logic [2:0]          romSel,
    output logic [ADDR_W-1:0]   romAddr,
    input  logic [COLOUR_W-1:0] romData,
    output logic [8:0]          vgaX,
    output logic [7:0]          vgaY,
    output logic [COLOUR_W-1:0] vgaColour,
    output logic                plot,
    output logic                busy,
    output logic                doneRedraw
);

    redraw_state_e stateQ;
    redraw_state_e stateD;

    logic [3:0]        prevState;
    logic              completed;
    logic              plotPending;
    logic              stateChanged;
    logic              redrawReq;
    logic              trigger;
    logic              loadRegion;
    logic              stepPixel;
    logic              lastPixel;
    logic [8:0]        curX;
    logic [7:0]        curY;
    logic [ADDR_W-1:0] curAddr;
    region_t           region;

    assign stateChanged = (gameState != prevState);
    assign redrawReq    = is_redraw_state(gameState);
    // Re-entry without a state change only redraws if the last redraw of this state never finished.
    assign trigger      = redrawReq && (stateChanged || !completed);
    assign region       = region_lookup(gameState);
    assign loadRegion   = (stateQ == ST_SETUP);
    assign stepPixel    = (stateQ == ST_SWEEP);

    redraw_addr_gen u_addr_gen (
        .clock  (clock),
        .resetn (resetn),
        .load   (loadRegion),
        .step   (stepPixel),
        .x0     (region.x0),
        .y0     (region.y0),
        .w      (region.w),
        .h      (region.h),
        .x      (curX),
        .y      (curY),
        .addr   (curAddr),
        .last   (lastPixel)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            ST_IDLE: begin
                if (trigger) stateD = ST_SETUP;
            end
            ST_SETUP: begin
                if (stateChanged) stateD = redrawReq ? ST_SETUP : ST_IDLE;
                else              stateD = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (stateChanged)   stateD = redrawReq ? ST_SETUP : ST_IDLE;
                else if (lastPixel) stateD = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (stateChanged) stateD = redrawReq ? ST_SETUP : ST_IDLE;
                else              stateD = ST_DONE;
            end
            ST_DONE: begin
                stateD = ST_IDLE;
            end
            default: stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prevState <= GS_INITIAL;
            completed <= 1'b0;
        end else begin
            prevState <= gameState;
            if (stateChanged)            completed <= 1'b0;
            else if (stateQ == ST_DONE)  completed <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            romSel <= '0;
        end else if (loadRegion) begin
            romSel <= region.sel;
        end
    end

    // Coordinates trail the address by one cycle to line up with romData; an abort drops the in-flight pixel.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            plotPending <= 1'b0;
            vgaX        <= '0;
            vgaY        <= '0;
        end else begin
            plotPending <= stepPixel && !stateChanged;
            if (stepPixel) begin
                vgaX <= curX;
                vgaY <= curY;
            end
        end
    end

`ifdef REDRAW_TRANSPARENT_EN
    assign plot = plotPending && (romData != KEY_COLOUR);
`else
    assign plot = plotPending;
`endif

    assign vgaColour  = plotPending ? romData : '0;
    assign romAddr    = stepPixel ? curAddr : '0;
    assign busy       = (stateQ != ST_IDLE);
    assign doneRedraw = (stateQ == ST_DONE);

endmodule

// File: tb/tb_background_redraw_ctrl.sv
// Randomized bench for background_redraw_ctrl: a cycle-stamped plot/done model built from the region table.
module tb_background_redraw_ctrl;

    localparam int MAXC = 90000;
    localparam int BIG  = 32'h3fffffff;

    typedef struct packed {
        logic [31:0] cyc;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [8:0]  c;
    } ev_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  gameState;
    logic [2:0]  romSel;
    logic [16:0] romAddr;
    logic [8:0]  romData;
    logic [8:0]  vgaX;
    logic [7:0]  vgaY;
    logic [8:0]  vgaColour;
    logic        plot;
    logic        busy;
    logic        doneRedraw;

    int          cyc = 0;
    int          nTests = 0;
    int          nFail = 0;
    int unsigned seed;

    ev_t expPlots[$];
    ev_t obsPlots[$];
    int  expDone[$];
    int  obsDone[$];
    logic        busyHist [0:MAXC-1];
    logic [16:0] addrHist [0:MAXC-1];

    background_redraw_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .gameState  (gameState),
        .romSel     (romSel),
        .romAddr    (romAddr),
        .romData    (romData),
        .vgaX       (vgaX),
        .vgaY       (vgaY),
        .vgaColour  (vgaColour),
        .plot       (plot),
        .busy       (busy),
        .doneRedraw (doneRedraw)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [8:0] rom_fn(input int unsigned addr);
        int unsigned v;
`ifdef REDRAW_TRANSPARENT_EN
        if (addr % 2 == 0) return 9'h000;
`endif
        v = ((addr * 37 + seed) % 511) + 1;
        return v[8:0];
    endfunction

    always @(posedge clock) romData <= rom_fn(32'(romAddr));

    always @(negedge clock) begin
        if (cyc < MAXC) begin
            busyHist[cyc] = busy;
            addrHist[cyc] = romAddr;
        end
        if (resetn) begin
            if (plot) obsPlots.push_back({32'(cyc), vgaX, vgaY, vgaColour});
            if (doneRedraw) obsDone.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic region_of(input int s, output int x0, output int y0, output int w, output int h, output int sel);
        case (s)
            10:      begin x0 = 0;  y0 = 0;  w = 320; h = 240; sel = 0; end
            1:       begin x0 = 0;  y0 = 0;  w = 8;   h = 4;   sel = 1; end
            3:       begin x0 = 8;  y0 = 4;  w = 8;   h = 4;   sel = 2; end
            5:       begin x0 = 16; y0 = 8;  w = 8;   h = 4;   sel = 3; end
            default: begin x0 = 24; y0 = 12; w = 8;   h = 4;   sel = 4; end
        endcase
    endtask

    // Redraw of state s triggered in cycle t; anything later than cycle cut never happens.
    task automatic model_region(input int t, input int s, input int cut);
        int x0, y0, w, h, sel, px, py, pc;
        ev_t e;
        region_of(s, x0, y0, w, h, sel);
        for (int i = 0; i < w * h; i++) begin
            pc = t + 3 + i;
            if (pc > cut) break;
            px = x0 + i % w;
            py = y0 + i / w;
            e.cyc = 32'(pc);
            e.x   = 9'(px);
            e.y   = 8'(py);
            e.c   = rom_fn(32'(py * 320 + px));
`ifdef REDRAW_TRANSPARENT_EN
            if (e.c == 9'h000) continue;
`endif
            expPlots.push_back(e);
        end
        if (t + 3 + w * h <= cut) expDone.push_back(t + 3 + w * h);
    endtask

    task automatic compare_queues(input string tag);
        int n;
        check({tag, "_nplots"}, 64'(obsPlots.size()), 64'(expPlots.size()));
        n = (obsPlots.size() < expPlots.size()) ? obsPlots.size() : expPlots.size();
        for (int i = 0; i < n; i++) check({tag, "_plot"}, 64'(obsPlots[i]), 64'(expPlots[i]));
        check({tag, "_ndone"}, 64'(obsDone.size()), 64'(expDone.size()));
        n = (obsDone.size() < expDone.size()) ? obsDone.size() : expDone.size();
        for (int i = 0; i < n; i++) check({tag, "_done_cyc"}, 64'(obsDone[i]), 64'(expDone[i]));
        obsPlots.delete(); expPlots.delete(); obsDone.delete(); expDone.delete();
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_at(input int k, input logic [3:0] v);
        wait_until(k);
        gameState = v;
    endtask

    initial begin
        int t, c, s, s2, mode, x0, y0, w, h, sel;
        int redrawSet[4];
        int otherSet[6];
        redrawSet = '{1, 3, 5, 7};
        otherSet  = '{0, 2, 4, 6, 8, 9};
        seed      = $urandom_range(0, 4095);
        resetn    = 1'b0;
        gameState = 4'd10;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_plot", 64'(plot), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(doneRedraw), 64'd0);
        check("rst_romAddr", 64'(romAddr), 64'd0);
        check("rst_romSel", 64'(romSel), 64'd0);
        check("rst_vgaX", 64'(vgaX), 64'd0);
        check("rst_vgaY", 64'(vgaY), 64'd0);
        check("rst_colour", 64'(vgaColour), 64'd0);

        // Full-screen initial draw straight out of reset.
        @(posedge clock);
        #1;
        resetn = 1'b1;
        t = cyc;
        model_region(t, 10, BIG);
        wait_until(t + 76806);
        check("full_busy_trig", 64'(busyHist[t]), 64'd0);
        check("full_busy_setup", 64'(busyHist[t + 1]), 64'd1);
        check("full_addr_first", 64'(addrHist[t + 2]), 64'd0);
        check("full_addr_last", 64'(addrHist[t + 76801]), 64'd76799);
        check("full_busy_after", 64'(busyHist[t + 76804]), 64'd0);
        check("full_romSel", 64'(romSel), 64'd0);
        compare_queues("full");

        drive_at(cyc + 1, 4'd0);
        drive_at(cyc + 3, 4'd1);
        t = cyc;
        model_region(t, 1, BIG);
        wait_until(t + 40);
        check("r1_busy_done", 64'(busyHist[t + 35]), 64'd1);
        check("r1_busy_after", 64'(busyHist[t + 36]), 64'd0);
        check("r1_romSel", 64'(romSel), 64'd1);
        compare_queues("r1");

        wait_until(cyc + 200);
        compare_queues("hold");

        // Switch 1 -> 3 on the cycle of the 10th plot.
        drive_at(cyc + 1, 4'd0);
        drive_at(cyc + 2, 4'd1);
        t = cyc;
        c = t + 12;
        drive_at(c, 4'd3);
        model_region(t, 1, c);
        model_region(c, 3, BIG);
        wait_until(c + 40);
        check("r13_romSel", 64'(romSel), 64'd2);
        compare_queues("r13");

        drive_at(cyc + 1, 4'd0);
        drive_at(cyc + 2, 4'd3);
        t = cyc;
        c = t + $urandom_range(2, 34);
        drive_at(c, 4'd4);
        model_region(t, 3, c);
        wait_until(c + 40);
        check("r34_busy_after", 64'(busyHist[c + 1]), 64'd0);
        compare_queues("r34");

        for (int it = 0; it < 6; it++) begin
            s    = redrawSet[$urandom_range(0, 3)];
            mode = $urandom_range(0, 2);
            drive_at(cyc + 1, 4'd0);
            drive_at(cyc + 1 + $urandom_range(0, 2), 4'(s));
            t = cyc;
            if (mode == 0) begin
                model_region(t, s, BIG);
                wait_until(t + 40);
                region_of(s, x0, y0, w, h, sel);
                check("rand_romSel", 64'(romSel), 64'(sel));
            end else begin
                c = t + $urandom_range(2, 34);
                if (mode == 1) begin
                    s2 = s;
                    while (s2 == s) s2 = redrawSet[$urandom_range(0, 3)];
                    drive_at(c, 4'(s2));
                    model_region(t, s, c);
                    model_region(c, s2, BIG);
                end else begin
                    drive_at(c, 4'(otherSet[$urandom_range(0, 5)]));
                    model_region(t, s, c);
                end
                wait_until(c + 40);
            end
            compare_queues("rand");
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
